// File: rtl/spi_seq_reader.sv
// SPI NOR byte-fetch engine: issues READ (0x03) + 24-bit address, then keeps the
// flash selected in HOLD so a read of the next sequential byte streams without a new command.
module spi_seq_reader #(
   parameter int CLKDIV       = 1,
   parameter int HOLD_TIMEOUT = 64,
   parameter int CSH_CYCLES   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [23:0] addr,
   output logic        busy,
   output logic [7:0]  rdata,
   output logic        rvalid,
   output logic        SPI_CLK,
   output logic        SPI_CS_n,
   output logic        SPI_MOSI,
   input  logic        SPI_MISO
);

   // Handshake: a request is taken on any clk edge where req=1 and busy=0; busy stays
   // high until the cycle rvalid pulses, and req seen while busy=1 is dropped.

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_HOLD, S_DESEL
   } state_t;

   localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
   localparam int CW = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;
   localparam logic [3:0]    DIV_LAST  = 4'(CLKDIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);
   localparam logic [CW-1:0] CSH_LAST  = CW'(CSH_CYCLES - 1);
   localparam logic [7:0]    CMD_READ  = 8'h03;

   state_t        state, state_n;
   logic [3:0]    div_cnt, div_cnt_n;
   logic [4:0]    bit_cnt, bit_cnt_n;
   logic [HW-1:0] hold_cnt, hold_cnt_n;
   logic [CW-1:0] csh_cnt, csh_cnt_n;
   logic [31:0]   tx_sr, tx_sr_n;
   logic [7:0]    rx_sr, rx_sr_n;
   logic [23:0]   addr_q, addr_q_n;
   logic [23:0]   next_addr, next_addr_n;
   logic          seq_valid, seq_valid_n;
   logic          pend, pend_n;
   logic          busy_n, rvalid_n, sck_n, cs_n_n, mosi_n;
   logic [7:0]    rdata_n;

   logic          accept;
   logic          half_end;
   logic [23:0]   cmd_addr;
   logic [31:0]   cmd_word;

   assign accept   = req & ~busy;
   assign half_end = (div_cnt == DIV_LAST);

   always_comb begin
      state_n     = state;
      div_cnt_n   = div_cnt;
      bit_cnt_n   = bit_cnt;
      hold_cnt_n  = hold_cnt;
      csh_cnt_n   = csh_cnt;
      tx_sr_n     = tx_sr;
      rx_sr_n     = rx_sr;
      addr_q_n    = addr_q;
      next_addr_n = next_addr;
      seq_valid_n = seq_valid;
      pend_n      = pend;
      busy_n      = busy;
      rvalid_n    = 1'b0;
      rdata_n     = rdata;
      sck_n       = SPI_CLK;
      cs_n_n      = SPI_CS_n;
      mosi_n      = SPI_MOSI;
      cmd_addr    = (state == S_DESEL && !accept) ? addr_q : addr;
      cmd_word    = {CMD_READ, cmd_addr};

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n   = S_CMD;
               addr_q_n  = addr;
               tx_sr_n   = cmd_word;
               mosi_n    = cmd_word[31];
               cs_n_n    = 1'b0;
               busy_n    = 1'b1;
               div_cnt_n = '0;
               bit_cnt_n = '0;
            end
         end

         S_CMD, S_ADDR, S_DATA: begin
            if (!half_end) begin
               div_cnt_n = div_cnt + 4'd1;
            end else begin
               div_cnt_n = '0;
               if (!SPI_CLK) begin
                  sck_n = 1'b1;
                  if (state == S_DATA) rx_sr_n = {rx_sr[6:0], SPI_MISO};
               end else begin
                  // Falling SCK closes a bit; all state changes happen with SCK low.
                  sck_n     = 1'b0;
                  tx_sr_n   = {tx_sr[30:0], 1'b0};
                  mosi_n    = (state == S_DATA) ? 1'b0 : tx_sr[30];
                  bit_cnt_n = bit_cnt + 5'd1;
                  if (state == S_CMD && bit_cnt == 5'd7) begin
                     state_n   = S_ADDR;
                     bit_cnt_n = '0;
                  end else if (state == S_ADDR && bit_cnt == 5'd23) begin
                     state_n   = S_DATA;
                     bit_cnt_n = '0;
                     mosi_n    = 1'b0;
                  end else if (state == S_DATA && bit_cnt == 5'd7) begin
                     state_n   = S_DONE;
                     bit_cnt_n = '0;
                  end
               end
            end
         end

         S_DONE: begin
            state_n     = S_HOLD;
            rvalid_n    = 1'b1;
            rdata_n     = rx_sr;
            busy_n      = 1'b0;
            next_addr_n = addr_q + 24'd1;
            seq_valid_n = 1'b1;
            hold_cnt_n  = '0;
         end

         S_HOLD: begin
            if (accept) begin
               addr_q_n = addr;
               busy_n   = 1'b1;
               if (seq_valid && addr == next_addr) begin
                  state_n   = S_DATA;
                  div_cnt_n = '0;
                  bit_cnt_n = '0;
               end else begin
                  state_n     = S_DESEL;
                  cs_n_n      = 1'b1;
                  seq_valid_n = 1'b0;
                  pend_n      = 1'b1;
                  csh_cnt_n   = '0;
               end
            end else if (hold_cnt == HOLD_LAST) begin
               state_n     = S_DESEL;
               cs_n_n      = 1'b1;
               seq_valid_n = 1'b0;
               pend_n      = 1'b0;
               csh_cnt_n   = '0;
            end else begin
               hold_cnt_n = hold_cnt + HW'(1);
            end
         end

         S_DESEL: begin
            // A request arriving after a timeout deselect is parked until CS_n high time is met.
            if (accept) begin
               pend_n   = 1'b1;
               addr_q_n = addr;
               busy_n   = 1'b1;
            end
            if (csh_cnt == CSH_LAST) begin
               pend_n = 1'b0;
               if (pend || accept) begin
                  state_n   = S_CMD;
                  tx_sr_n   = cmd_word;
                  mosi_n    = cmd_word[31];
                  cs_n_n    = 1'b0;
                  div_cnt_n = '0;
                  bit_cnt_n = '0;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               csh_cnt_n = csh_cnt + CW'(1);
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         hold_cnt  <= '0;
         csh_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         addr_q    <= '0;
         next_addr <= '0;
         seq_valid <= 1'b0;
         pend      <= 1'b0;
         busy      <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= 8'h00;
         SPI_CLK   <= 1'b0;
         SPI_CS_n  <= 1'b1;
         SPI_MOSI  <= 1'b0;
      end else begin
         state     <= state_n;
         div_cnt   <= div_cnt_n;
         bit_cnt   <= bit_cnt_n;
         hold_cnt  <= hold_cnt_n;
         csh_cnt   <= csh_cnt_n;
         tx_sr     <= tx_sr_n;
         rx_sr     <= rx_sr_n;
         addr_q    <= addr_q_n;
         next_addr <= next_addr_n;
         seq_valid <= seq_valid_n;
         pend      <= pend_n;
         busy      <= busy_n;
         rvalid    <= rvalid_n;
         rdata     <= rdata_n;
         SPI_CLK   <= sck_n;
         SPI_CS_n  <= cs_n_n;
         SPI_MOSI  <= mosi_n;
      end
   end

endmodule

// File: tb/tb_spi_seq_reader.sv
// Bench for spi_seq_reader: SPI NOR flash model, rdata/latency scoreboard,
// command-frame scoreboard and an SCK/CS_n protocol monitor.
module tb_spi_seq_reader;
   localparam int CLKDIV       = 1;
   localparam int HOLD_TIMEOUT = 64;
   localparam int CSH_CYCLES   = 4;
   localparam int LAT_COLD = 1 + 80 * CLKDIV;
   localparam int LAT_SEQ  = 1 + 16 * CLKDIV;
   localparam int LAT_MISS = 1 + CSH_CYCLES + 80 * CLKDIV;

   logic        CLK_50M = 1'b0;
   logic        rst, req;
   logic [23:0] addr;
   logic        busy, rvalid;
   logic [7:0]  rdata;
   logic        SPI_CLK, SPI_CS_n, SPI_MOSI;
   logic        miso = 1'b0;

   spi_seq_reader #(.CLKDIV(CLKDIV), .HOLD_TIMEOUT(HOLD_TIMEOUT), .CSH_CYCLES(CSH_CYCLES)) dut (
      .clk(CLK_50M), .rst(rst), .req(req), .addr(addr), .busy(busy), .rdata(rdata),
      .rvalid(rvalid), .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n), .SPI_MOSI(SPI_MOSI),
      .SPI_MISO(miso)
   );

   // ---------------- clock / reset ----------------
   always #10 CLK_50M = ~CLK_50M;

   int cyc = 0;
   always @(posedge CLK_50M) cyc <= cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      if (a == 24'h000100) return 8'hA5;
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
   endfunction

   // ---------------- flash model ----------------
   logic [23:0] exp_q[$];   // {latency[15:0], rdata[7:0]}
   logic [31:0] cmd_q[$];   // expected {cmd, addr} frames
   int          fl_bits = 0;
   logic [31:0] fl_sr = '0;
   logic [23:0] fl_addr = '0;

   always @(negedge SPI_CS_n) fl_bits = 0;
   always @(posedge SPI_CS_n) miso = 1'b0;

   always @(posedge SPI_CLK) begin
      if (SPI_CS_n === 1'b0) begin
         if (fl_bits < 32) begin
            fl_sr = {fl_sr[30:0], SPI_MOSI};
            if (fl_bits == 31) begin
               fl_addr = fl_sr[23:0];
               if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(cmd_q.size()), 1);
               else                   chk("cmd_frame", fl_sr, cmd_q.pop_front());
            end
         end
         fl_bits++;
      end
   end

   always @(negedge SPI_CLK) begin
      if (SPI_CS_n === 1'b0 && fl_bits >= 32) begin
         int idx;
         logic [7:0] b;
         idx  = fl_bits - 32;
         b    = mem_byte(fl_addr + 24'(idx / 8));
         miso = b[7 - (idx % 8)];
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   int rv_cnt  = 0;
   int req_cyc = 0;
   logic sck_prev = 1'b0, cs_prev = 1'b1;
   int hi_cnt = 0, gap = 100, last_gap = 0;

   always @(negedge CLK_50M) begin
      if (rst === 1'b0) begin
         if (rvalid === 1'b1) begin
            rv_cnt++;
            if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(exp_q.size()), 1);
            else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk("rdata", 32'(rdata), 32'(e[7:0]));
               chk("latency", 32'(cyc - req_cyc), 32'(e[23:8]));
            end
         end
         if (SPI_CS_n !== cs_prev) begin
            chk("cs_change_sck_low", {30'b0, sck_prev, SPI_CLK}, 0);
            if (SPI_CS_n === 1'b0) begin
               chk("csh_min", 32'(gap >= CSH_CYCLES), 1);
               last_gap = gap;
            end
            gap = 0;
         end
         if (SPI_CS_n === 1'b1) gap++;
         if (SPI_CLK === 1'b1) hi_cnt++;
         else if (hi_cnt != 0) begin
            chk("sck_high_width", 32'(hi_cnt), 32'(CLKDIV));
            hi_cnt = 0;
         end
      end
      sck_prev = SPI_CLK;
      cs_prev  = SPI_CS_n;
   end

   // ---------------- driver tasks ----------------
   logic        hold_ok = 1'b0;
   logic [23:0] next_a  = '0;

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge CLK_50M);
         n++;
      end while (busy !== 1'b0 && n < 400);
      if (busy !== 1'b0) chk("busy_timeout", 32'(busy), 0);
   endtask

   task automatic issue(input logic [23:0] a, input int lat, input bit new_cmd);
      wait_idle();
      req  = 1'b1;
      addr = a;
      exp_q.push_back({16'(lat), mem_byte(a)});
      if (new_cmd) cmd_q.push_back({8'h03, a});
      @(negedge CLK_50M);
      req     = 1'b0;
      req_cyc = cyc;
      chk("busy_on_accept", 32'(busy), 1);
   endtask

   task automatic wait_rv(input int n0);
      int n;
      n = 0;
      while (rv_cnt == n0 && n < 300) begin
         @(negedge CLK_50M);
         n++;
      end
      if (rv_cnt == n0) begin
         chk("rvalid_timeout", 32'(rv_cnt - n0), 1);
         exp_q.delete();
      end
   endtask

   task automatic read_auto(input logic [23:0] a);
      bit hit;
      int n0;
      hit = hold_ok && (a == next_a);
      n0  = rv_cnt;
      issue(a, hit ? LAT_SEQ : (hold_ok ? LAT_MISS : LAT_COLD), !hit);
      wait_rv(n0);
      hold_ok = 1'b1;
      next_a  = a + 24'd1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n0;
      logic [23:0] a;
      rst  = 1'b1;
      req  = 1'b0;
      addr = '0;
      repeat (3) @(negedge CLK_50M);
      chk("rst_cs_n", 32'(SPI_CS_n), 1);
      chk("rst_sck", 32'(SPI_CLK), 0);
      chk("rst_mosi", 32'(SPI_MOSI), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      rst = 1'b0;
      @(negedge CLK_50M);

      // cold read, then CS_n held low in HOLD
      read_auto(24'h000100);
      repeat (3) @(negedge CLK_50M);
      chk("cs_held_in_hold", 32'(SPI_CS_n), 0);

      // sequential hit, then miss with exact CS_n high gap
      repeat (1) @(negedge CLK_50M);
      read_auto(24'h000101);
      read_auto(24'h000200);
      chk("csh_gap_exact", 32'(last_gap), 32'(CSH_CYCLES));

      // hold timeout, then cold path again
      repeat (HOLD_TIMEOUT - 8) @(negedge CLK_50M);
      chk("cs_before_timeout", 32'(SPI_CS_n), 0);
      repeat (16) @(negedge CLK_50M);
      chk("cs_after_timeout", 32'(SPI_CS_n), 1);
      hold_ok = 1'b0;
      repeat (10) @(negedge CLK_50M);
      read_auto(24'h000102);

      // address wrap streams
      read_auto(24'hFFFFFF);
      read_auto(24'h000000);

      // req while busy is ignored
      n0 = rv_cnt;
      issue(24'h000300, LAT_MISS, 1'b1);
      for (int i = 0; i < 3; i++) begin
         repeat (5) @(negedge CLK_50M);
         req  = 1'b1;
         addr = 24'h000777 + 24'(i);
         @(negedge CLK_50M);
         req  = 1'b0;
      end
      wait_rv(n0);
      hold_ok = 1'b1;
      next_a  = 24'h000301;
      repeat (20) @(negedge CLK_50M);
      chk("one_rvalid_per_req", 32'(rv_cnt - n0), 1);
      read_auto(24'h000301);

      // reset during ADDR bit 10 (miss path: CSH gap then CMD)
      n0 = rv_cnt;
      issue(24'h000400, LAT_MISS, 1'b1);
      repeat (CSH_CYCLES + 36 * CLKDIV) @(negedge CLK_50M);
      rst = 1'b1;
      @(negedge CLK_50M);
      chk("midrst_cs_n", 32'(SPI_CS_n), 1);
      chk("midrst_sck", 32'(SPI_CLK), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_rvalid", 32'(rvalid), 0);
      rst = 1'b0;
      exp_q.delete();
      cmd_q.delete();
      hold_ok = 1'b0;
      repeat (150) @(negedge CLK_50M);
      chk("no_rvalid_after_rst", 32'(rv_cnt - n0), 0);
      read_auto(24'h000400);

      // random mix of sequential hits and misses
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge CLK_50M);
         a = ($urandom_range(0, 1) == 1) ? next_a : 24'($urandom_range(0, 24'hFFFFFF));
         read_auto(a);
      end

      repeat (5) @(negedge CLK_50M);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("cmd_q_drained", 32'(cmd_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
